multi_chan_xfer: RTL

MULTI_CHAN_XFER -- requirements
Module: multi_chan_xfer

---
 rtl/multi_chan_xfer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/multi_chan_xfer.sv
// Multi-channel FIFO-to-ring-buffer transfer engine: on each event it pops the header
// FIFO, then reads NSAMP samples from every unmasked channel. Optional macro: XFER_UFLOW_CNT_EN.
module multi_chan_xfer #(
    parameter int NCHAN = 16,
    parameter int DW    = 12,
    parameter int NSAMP = 8,
    localparam int CHW  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                jtag_mode,
    input  logic                j_rd_fifo,
    input  logic                rdy,
    input  logic [NCHAN*DW-1:0] din,
    input  logic [NCHAN-1:0]    ch_mt,
    input  logic [NCHAN-1:0]    ch_mask,
    output logic [NCHAN-1:0]    rd_ena,
    output logic                l1a_rd_en,
    output logic                wren,
    output logic [DW-1:0]       dmux,
    output logic [CHW-1:0]      chan_tag,
    output logic                busy,
    output logic                done,
    output logic [15:0]         uflow_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1A,
        S_SCAN,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [CHW-1:0] LAST_CH   = CHW'(NCHAN - 1);
    localparam logic [7:0]     LAST_SAMP = 8'(NSAMP - 1);

    state_t             state_q, state_d;
    logic [CHW-1:0]     ptr_q, ptr_d;
    logic [7:0]         samp_q, samp_d;
    logic [NCHAN-1:0]   mask_q, mask_d;
    logic               pend_q, pend_d;
    logic               re;
    logic               re_d1_q, re_d1_d;
    logic [CHW-1:0]     ptr_d1_q, ptr_d1_d;
    logic [NCHAN-1:0]   rd_ena_q, rd_ena_d;
    logic               wren_q, wren_d;
    logic [DW-1:0]      dmux_q, dmux_d;
    logic [CHW-1:0]     chan_tag_q, chan_tag_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        samp_d  = samp_q;
        mask_d  = mask_q;
        pend_d  = pend_q;
        re      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rdy || pend_q) begin
                    state_d = S_L1A;
                    mask_d  = ch_mask;
                end
            end
            S_L1A: begin
                ptr_d   = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                if (!mask_q[ptr_q]) begin
                    state_d = S_READ;
                    samp_d  = '0;
                end else if (ptr_q == LAST_CH) begin
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + CHW'(1);
                end
            end
            S_READ: begin
                re     = 1'b1;
                samp_d = samp_q + 8'd1;
                if (samp_q == LAST_SAMP) begin
                    if (ptr_q == LAST_CH) begin
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + CHW'(1);
                        state_d = S_SCAN;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // One-deep event queue; a request arriving while one is pending is dropped.
        if (state_q == S_IDLE && (rdy || pend_q)) begin
            pend_d = 1'b0;
        end else if (rdy && state_q != S_IDLE) begin
            pend_d = 1'b1;
        end

        // JTAG override abandons everything and takes precedence over RDY.
        if (jtag_mode) begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
            re      = 1'b0;
            mask_d  = mask_q;
        end
    end

    always_comb begin
        re_d1_d    = re;
        ptr_d1_d   = ptr_q;
        wren_d     = re_d1_q && !jtag_mode;
        dmux_d     = dmux_q;
        chan_tag_d = chan_tag_q;
        rd_ena_d   = '0;
        if (re_d1_q) begin
            dmux_d     = din[ptr_d1_q*DW +: DW];
            chan_tag_d = ptr_d1_q;
        end
        if (jtag_mode) begin
            rd_ena_d = {NCHAN{j_rd_fifo}};
        end else if (re) begin
            rd_ena_d[ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            samp_q     <= '0;
            mask_q     <= '0;
            pend_q     <= 1'b0;
            re_d1_q    <= 1'b0;
            ptr_d1_q   <= '0;
            rd_ena_q   <= '0;
            wren_q     <= 1'b0;
            dmux_q     <= '0;
            chan_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            samp_q     <= samp_d;
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            re_d1_q    <= re_d1_d;
            ptr_d1_q   <= ptr_d1_d;
            rd_ena_q   <= rd_ena_d;
            wren_q     <= wren_d;
            dmux_q     <= dmux_d;
            chan_tag_q <= chan_tag_d;
        end
    end

`ifdef XFER_UFLOW_CNT_EN
    logic [15:0] uflow_q, uflow_d;

    always_comb begin
        uflow_d = uflow_q;
        if (re && ch_mt[ptr_q] && uflow_q != 16'hFFFF) begin
            uflow_d = uflow_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uflow_q <= '0;
        end else begin
            uflow_q <= uflow_d;
        end
    end

    assign uflow_cnt = uflow_q;
`else
    assign uflow_cnt = 16'd0;
`endif

    assign rd_ena    = rd_ena_q;
    assign wren      = wren_q;
    assign dmux      = dmux_q;
    assign chan_tag  = chan_tag_q;
    assign l1a_rd_en = (state_q == S_L1A) && !jtag_mode;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule
